// File: rtl/busdebugger_command.sv
// Command front end for the serial bus debugger.
// Decodes single-byte host commands from usart_rx into snooper control pulses,
// answers each command with one byte on usart_tx, and forwards the snooper's
// dump stream to usart_tx while a dump is running.
module busdebugger_command #(
    parameter logic [7:0] ACK_BYTE = 8'h4B,  // 'K'
    parameter logic [7:0] NAK_BYTE = 8'h45   // 'E'
) (
    input  logic       comm_clock,
    input  logic       reset,
    // usart_rx side
    input  logic [7:0] rx_data,
    input  logic       rx_available,
    input  logic       rx_error,
    output logic       rx_acknowledge,
    // snooper control / dump stream
    output logic       record_start,
    output logic       record_trigger,
    output logic       dump_start,
    input  logic       record_end,
    input  logic       dump_end,
    input  logic [7:0] snoop_data,
    input  logic       snoop_valid,
    output logic       snoop_ready,
    // usart_tx side
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    // status
    output logic       busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACK     = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;
    localparam logic [1:0] S_DUMPING = 2'd3;

    localparam logic [7:0] CMD_RECORD  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_TRIGGER = 8'h54;  // 'T'
    localparam logic [7:0] CMD_DUMP    = 8'h44;  // 'D'
    localparam logic [7:0] CMD_STATUS  = 8'h3F;  // '?'

    logic [1:0] r_state;
    logic [7:0] r_cmd;        // byte latched from usart_rx
    logic       r_cmd_err;    // framing error latched with that byte
    logic       r_first;      // first cycle of ACK: decode/pulse cycle
    logic [7:0] r_resp;       // response byte held for RESPOND
    logic       r_recording;
    logic       r_done;

    logic       w_decode;
    logic       w_is_rec;
    logic       w_is_trig;
    logic       w_is_dump;
    logic       w_is_stat;
    logic [7:0] w_status;
    logic [7:0] w_resp_dec;

    // A latched rx_error masks every command match, so an errored byte
    // falls through to NAK with no pulse.
    assign w_decode  = (r_state == S_ACK) && r_first;
    assign w_is_rec  = !r_cmd_err && (r_cmd == CMD_RECORD);
    assign w_is_trig = !r_cmd_err && (r_cmd == CMD_TRIGGER);
    assign w_is_dump = !r_cmd_err && (r_cmd == CMD_DUMP);
    assign w_is_stat = !r_cmd_err && (r_cmd == CMD_STATUS);
    assign w_status  = 8'h30 | {6'b0, r_done, r_recording};

    // Response byte chosen on the decode cycle; 'D' answers later with ACK_BYTE.
    always_comb begin
        w_resp_dec = NAK_BYTE;
        if (w_is_rec || w_is_trig)
            w_resp_dec = ACK_BYTE;
        else if (w_is_stat)
            w_resp_dec = w_status;
    end

    // Command FSM: latch byte, hold handshake, respond or stream a dump.
    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= 8'h00;
            r_cmd_err <= 1'b0;
            r_first   <= 1'b0;
            r_resp    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_available) begin
                        r_cmd     <= rx_data;
                        r_cmd_err <= rx_error;
                        r_first   <= 1'b1;
                        r_state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_first <= 1'b0;
                    if (w_decode)
                        r_resp <= w_resp_dec;
                    // Four-phase: hold acknowledge until usart_rx drops available.
                    if (!rx_available)
                        r_state <= w_is_dump ? S_DUMPING : S_RESPOND;
                end
                S_RESPOND: begin
                    if (tx_ready)
                        r_state <= S_IDLE;
                end
                S_DUMPING: begin
                    // Dump is terminated by an ACK_BYTE response.
                    if (dump_end) begin
                        r_resp  <= ACK_BYTE;
                        r_state <= S_RESPOND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Recording status flags; an 'R' decode beats a coincident record_end.
    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            r_recording <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_decode && w_is_rec) begin
            r_recording <= 1'b1;
            r_done      <= 1'b0;
        end else if (record_end) begin
            r_recording <= 1'b0;
            r_done      <= 1'b1;
        end
    end

    assign rx_acknowledge = (r_state == S_ACK);
    assign record_start   = w_decode && w_is_rec;
    assign record_trigger = w_decode && w_is_trig;
    assign dump_start     = w_decode && w_is_dump;
    assign busy           = (r_state != S_IDLE);
    assign snoop_ready    = (r_state == S_DUMPING) && tx_ready;

    // Transmit mux: held response in RESPOND, snooper pass-through in DUMPING.
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        case (r_state)
            S_RESPOND: begin
                tx_data  = r_resp;
                tx_valid = 1'b1;
            end
            S_DUMPING: begin
                tx_data  = snoop_data;
                tx_valid = snoop_valid;
            end
            default: begin
                tx_data  = 8'h00;
                tx_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/busdebugger_command.md
Name: busdebugger_command

Overview:
Command front end for the serial bus debugger. It sits between usart_rx and the bus snooper/usart_tx pair. It decodes single-byte host commands into the snooper's control pulses: record start, record trigger and dump start. It also owns the transmit path, sending a one-byte response per command and muxing the snooper's dump stream through to usart_tx while a dump is in progress.

Parameters:
ACK_BYTE, 8'h4B, response byte for an accepted R/T/D command ('K').
NAK_BYTE, 8'h45, response byte for an unknown command or an rx error ('E').

Ports:
comm_clock  in  1  system clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-high reset.
rx_data  in  8  received byte from usart_rx.
rx_available  in  1  rx_data is valid.
rx_error  in  1  framing error on the current byte.
rx_acknowledge  out  1  byte consumed (four-phase).
record_start  out  1  one-cycle pulse to the snooper.
record_trigger  out  1  one-cycle pulse to the snooper.
dump_start  out  1  one-cycle pulse to the snooper.
record_end  in  1  snooper capture buffer full / recording stopped.
dump_end  in  1  snooper finished dump (one-cycle pulse).
snoop_data  in  8  dump byte from the snooper.
snoop_valid  in  1  snoop_data is valid.
snoop_ready  out  1  ready back to the snooper.
tx_data  out  8  byte to usart_tx.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  usart_tx can accept a byte.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE; status flags clear; any pending response is dropped.
  - rx_acknowledge, record_start, record_trigger, dump_start, snoop_ready, tx_valid and busy are 0; tx_data is 8'h00.
- FSM states: IDLE, ACK, RESPOND, DUMPING.
- IDLE:
  - When rx_available=1, latch rx_data and rx_error and go to ACK.
  - rx_available is ignored in every other state; this is the backpressure to usart_rx.
- ACK:
  - rx_acknowledge=1 for the whole state.
  - On the first ACK cycle only, emit the decoded pulse (decode rules below).
  - Leave ACK only when rx_available=0. Go to DUMPING for a valid 'D' command, otherwise go to RESPOND.
- Decode of the latched byte (an rx_error latched with the byte overrides the decode):
  - rx_error latched: no pulse, response NAK_BYTE.
  - 8'h52 'R': pulse record_start; set recording=1, done=0; response ACK_BYTE.
  - 8'h54 'T': pulse record_trigger; response ACK_BYTE.
  - 8'h44 'D': pulse dump_start; no immediate response.
  - 8'h3F '?': no pulse; response is 8'h30 | {6'b0, done, recording}, i.e. ASCII '0'..'3'.
  - Any other byte: no pulse; response NAK_BYTE.
- Status flags:
  - A record_end=1 sample sets done=1 and recording=0.
  - If a record_end sample coincides with the 'R' decode cycle, 'R' wins (recording=1, done=0).
- RESPOND:
  - tx_data holds the response and tx_valid=1.
  - Transfer happens on a cycle with tx_valid & tx_ready; the next state is IDLE with tx_valid=0.
  - tx_data must be stable while tx_valid=1.
- DUMPING:
  - tx_data=snoop_data, tx_valid=snoop_valid and snoop_ready=tx_ready, all combinational pass-through.
  - On dump_end=1, load ACK_BYTE and go to RESPOND, so a dump is terminated by 'K'.
  - A byte transferring in the same cycle as dump_end is still passed through.
- Outside DUMPING: snoop_ready=0, and dump_end is ignored.
- busy = (state != IDLE).
- Latency from rx_available rising in IDLE:
  - rx_acknowledge and the pulse appear 1 cycle later.
  - The response tx_valid appears 1 cycle after rx_available falls.

Test Plan:
- Reset mid-dump: issue 'D', then assert reset while snoop_valid=1 -> all outputs 0 on the next cycle, state IDLE, snoop_ready=0, no 'K' sent afterwards.
- 'R' command, rx_available held for 3 cycles, tx_ready=1 -> record_start high for exactly 1 cycle, rx_acknowledge high until available drops, then tx_data=8'h4B for one transfer; a following '?' returns 8'h31.
- record_end pulse, then '?' -> response 8'h32; record_end asserted on the same cycle as the 'R' decode, then '?' -> 8'h31.
- 'D' with the snooper streaming 8'hA0..8'hA3 and tx_ready toggling every other cycle -> usart_tx receives A0, A1, A2, A3 in order with no duplicates or drops; dump_end pulse -> next transfer is 8'h4B; snoop_ready=0 afterwards.
- Byte 8'h5A, then a byte with rx_error=1 -> two 8'h45 responses; no control pulses emitted.
- Byte arriving while in RESPOND with tx_ready=0 for 10 cycles -> rx_acknowledge stays 0 until the response transfers; the byte is then processed normally.
